pipe_addsub: RTL and testbench

Parametrised, pipelined N-bit add/subtract unit with ripple borrow/carry split across STAGES register stages, valid/ready handshaking at both ends and signed/unsigned status flags. It is the next-generation arithmetic block for the CPU datapath, replacing a purely combinational ripple subtractor. It accepts one operation per cycle at full throughput and tolerates downstream backpressure without loss.

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_stage.sv | 24 ++
 rtl/pipe_addsub.sv | 148 ++++++++++++++
 tb/tb_pipe_addsub.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encoding and status flags.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cbo;
        logic zero;
        logic neg;
        logic ovf;
    } addsub_flags_t;

endpackage

// File: rtl/addsub_stage.sv
// One combinational W-bit slice of the ripple adder; subtract inverts b, while the
// carry-in is already in carry polarity (the top converts borrow-in for stage 0).
module addsub_stage
    import addsub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    input  logic         i_op,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W-1:0] w_b;
    logic [W:0]   w_total;

    assign w_b     = (i_op == OP_SUB) ? ~i_b : i_b;
    assign w_total = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, i_cin};
    assign o_sum   = w_total[W-1:0];
    assign o_cout  = w_total[W];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined N-bit add/subtract, one N/STAGES slice per stage, valid/ready at both ends.
// Optional build macro ADDSUB_SAT_EN clamps the result to the signed range on overflow.
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cbin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         cbo,
    output logic         zero,
    output logic         neg,
    output logic         ovf
);

    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    // Handshake: a transfer occurs on a rising edge where valid & ready are both high;
    // stage k loads whenever it is empty or the stage after it moves on, so bubbles collapse.
    logic [STAGES-1:0] w_valid_q;
    logic [STAGES-1:0] w_op_q;
    logic [STAGES-1:0] w_carry_q;
    logic [STAGES-1:0] w_ready;
    logic [N-1:0]      w_a_q   [STAGES];
    logic [N-1:0]      w_b_q   [STAGES];
    logic [N-1:0]      w_sum_q [STAGES];

    assign in_ready = w_ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         w_valid_in;
        logic         w_op_in;
        logic         w_cin_in;
        logic [N-1:0] w_a_in;
        logic [N-1:0] w_b_in;
        logic [N-1:0] w_sum_in;
        logic [N-1:0] w_sum_next;
        logic [W-1:0] w_slice;
        logic         w_cout;
        logic         r_valid;
        logic         r_op;
        logic         r_carry;
        logic [N-1:0] r_a;
        logic [N-1:0] r_b;
        logic [N-1:0] r_sum;

        if (k == 0) begin : g_first
            assign w_valid_in = in_valid;
            assign w_op_in    = op;
            assign w_cin_in   = (op == OP_SUB) ? ~cbin : cbin;
            assign w_a_in     = a;
            assign w_b_in     = b;
            assign w_sum_in   = '0;
        end else begin : g_next
            assign w_valid_in = w_valid_q[k-1];
            assign w_op_in    = w_op_q[k-1];
            assign w_cin_in   = w_carry_q[k-1];
            assign w_a_in     = w_a_q[k-1];
            assign w_b_in     = w_b_q[k-1];
            assign w_sum_in   = w_sum_q[k-1];
        end

        addsub_stage #(.W(W)) u_stage (
            .i_a    (w_a_in[k*W +: W]),
            .i_b    (w_b_in[k*W +: W]),
            .i_cin  (w_cin_in),
            .i_op   (w_op_in),
            .o_sum  (w_slice),
            .o_cout (w_cout)
        );

        always_comb begin
            w_sum_next              = w_sum_in;
            w_sum_next[k*W +: W]    = w_slice;
        end

        // Unrolled ready chain: stage k can load if any stage from k onward is empty.
        assign w_ready[k] = out_ready | ~(&w_valid_q[L:k]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_op    <= 1'b0;
                r_carry <= 1'b0;
                r_a     <= '0;
                r_b     <= '0;
                r_sum   <= '0;
            end else if (w_ready[k]) begin
                r_valid <= w_valid_in;
                r_op    <= w_op_in;
                r_carry <= w_cout;
                r_a     <= w_a_in;
                r_b     <= w_b_in;
                r_sum   <= w_sum_next;
            end
        end

        assign w_valid_q[k] = r_valid;
        assign w_op_q[k]    = r_op;
        assign w_carry_q[k] = r_carry;
        assign w_a_q[k]     = r_a;
        assign w_b_q[k]     = r_b;
        assign w_sum_q[k]   = r_sum;
    end

    logic          w_a_msb;
    logic          w_b_msb;
    logic          w_ovf;
    logic [N-1:0]  w_raw;
    logic [N-1:0]  w_res;
    addsub_flags_t w_flags;

    assign w_raw   = w_sum_q[L];
    assign w_a_msb = w_a_q[L][N-1];
    assign w_b_msb = w_b_q[L][N-1];
    assign w_ovf   = (w_op_q[L] == OP_ADD)
                   ? ((w_a_msb == w_b_msb) && (w_raw[N-1] != w_a_msb))
                   : ((w_a_msb != w_b_msb) && (w_raw[N-1] != w_a_msb));

`ifdef ADDSUB_SAT_EN
    assign w_res = !w_ovf ? w_raw
                 : (w_a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}});
`else
    assign w_res = w_raw;
`endif

    // Carry/borrow is reported raw; zero/neg follow the (possibly clamped) result.
    assign w_flags.cbo  = (w_op_q[L] == OP_SUB) ? ~w_carry_q[L] : w_carry_q[L];
    assign w_flags.zero = (w_res == '0);
    assign w_flags.neg  = w_res[N-1];
    assign w_flags.ovf  = w_ovf;

    assign out_valid             = w_valid_q[L];
    assign result                = out_valid ? w_res : '0;
    assign {cbo, zero, neg, ovf} = out_valid ? w_flags : '0;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (N=16, STAGES=4); honours ADDSUB_SAT_EN when defined.
module tb_pipe_addsub;

    localparam int N      = 16;
    localparam int STAGES = 4;
    localparam longint SMAX = (64'sd1 <<< (N-1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (N-1));

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cbin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] result;
    logic         cbo, zero, neg, ovf;

    int tests_run = 0;
    int tests_failed = 0;
    logic [N+3:0] exp_q[$];

    pipe_addsub #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cbin      (cbin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cbo       (cbo),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: wide unsigned arithmetic for carry/borrow, signed integers for overflow.
    function automatic logic [N+3:0] model(input logic op_i, input logic [N-1:0] a_i,
                                           input logic [N-1:0] b_i, input logic cbin_i);
        logic [N:0]   full;
        logic [N-1:0] r;
        longint       sa, sb, sr;
        logic         o;
        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        if (op_i == 1'b0) begin
            full = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cbin_i};
            sr   = sa + sb + longint'(cbin_i);
        end else begin
            full = {1'b0, a_i} - {1'b0, b_i} - {{N{1'b0}}, cbin_i};
            sr   = sa - sb - longint'(cbin_i);
        end
        o = (sr > SMAX) || (sr < SMIN);
        r = full[N-1:0];
`ifdef ADDSUB_SAT_EN
        if (o) r = (sr > 0) ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
`endif
        return {r, full[N], (r == '0), r[N-1], o};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({out_valid, result, cbo, zero, neg, ovf} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b, want all zero", {out_valid, result, cbo, zero, neg, ovf});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic         v_op [8];
        logic [N-1:0] v_a [8];
        logic [N-1:0] v_b [8];
        logic         v_ci [8];
        logic [N-1:0] e_res [8];
        logic [3:0]   e_flg [8];
        int           lat;
        v_op  = '{1, 1, 1, 0, 0, 1, 1, 0};
        v_a   = '{16'h1234, 16'h0000, 16'h0005, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h1234};
        v_b   = '{16'h0234, 16'h0001, 16'h0005, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'h4321};
        v_ci  = '{0, 0, 0, 1, 0, 0, 1, 0};
`ifdef ADDSUB_SAT_EN
        e_res = '{16'h1000, 16'hFFFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h5555};
        e_flg = '{4'b0000, 4'b1010, 4'b0100, 4'b1100, 4'b0001, 4'b0011, 4'b1010, 4'b0000};
`else
        e_res = '{16'h1000, 16'hFFFF, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h5555};
        e_flg = '{4'b0000, 4'b1010, 4'b0100, 4'b1100, 4'b0011, 4'b0001, 4'b1010, 4'b0000};
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            op = v_op[i]; a = v_a[i]; b = v_b[i]; cbin = v_ci[i];
            @(posedge clk);
            lat = 0;
            while (lat < 10) begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
                if (out_valid) break;
            end
            tests_run++;
            if (lat !== STAGES) begin
                tests_failed++;
                $display("FAIL vec%0d_latency: got %0d cycles, want %0d", i, lat, STAGES);
            end
            tests_run++;
            if (result !== e_res[i]) begin
                tests_failed++;
                $display("FAIL vec%0d_result: got %h, want %h", i, result, e_res[i]);
            end
            tests_run++;
            if ({cbo, zero, neg, ovf} !== e_flg[i]) begin
                tests_failed++;
                $display("FAIL vec%0d_flags(cbo,zero,neg,ovf): got %b, want %b", i, {cbo, zero, neg, ovf}, e_flg[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int   sent = 0, rcvd = 0, held = -1;
        logic saw_stall = 1'b0;
        logic [N+3:0] exp_v;
        exp_q.delete();
        for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc < 8);
            in_valid  = (sent < 8);
            op = sent[0]; a = 16'h1111 * (sent + 1); b = 16'h0101 * sent; cbin = sent[1];
            #1;
            if (cyc == 8) begin
                tests_run++;
                if (in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL bp_full_pass_through: in_ready got %b, want 1", in_ready);
                end
            end
            if (in_valid && !in_ready && !saw_stall) begin
                saw_stall = 1'b1;
                held = sent - rcvd;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, a, b, cbin));
                sent++;
            end
            if (out_valid && out_ready) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                tests_run++;
                if ({result, cbo, zero, neg, ovf} !== exp_v) begin
                    tests_failed++;
                    $display("FAIL bp_out%0d: got %h, want %h", rcvd, {result, cbo, zero, neg, ovf}, exp_v);
                end
                rcvd++;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (!saw_stall || held !== STAGES) begin
            tests_failed++;
            $display("FAIL bp_stall_depth: stall seen %b with %0d held, want 1 with %0d", saw_stall, held, STAGES);
        end
        tests_run++;
        if (rcvd !== 8 || exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d results, %0d pending, want 8 and 0", rcvd, exp_q.size());
        end
    endtask

    task automatic test_random(input int n_ops);
        int   sent = 0, rcvd = 0;
        logic [N+3:0] exp_v;
        logic [N-1:0] corner [4];
        corner = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
        exp_q.delete();
        for (int cyc = 0; cyc < 20 * n_ops && rcvd < n_ops; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < n_ops) && ($urandom_range(0, 3) != 0);
            op   = $urandom_range(0, 1);
            cbin = $urandom_range(0, 1);
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : N'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : N'($urandom);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, a, b, cbin));
                sent++;
            end
            if (out_valid && out_ready) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                tests_run++;
                if ({result, cbo, zero, neg, ovf} !== exp_v) begin
                    tests_failed++;
                    $display("FAIL rand_out%0d: got %h, want %h", rcvd, {result, cbo, zero, neg, ovf}, exp_v);
                end
                rcvd++;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (rcvd !== n_ops || exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d results, %0d pending, want %0d and 0", rcvd, exp_q.size(), n_ops);
        end
    endtask

    task automatic test_reset_inflight();
        int   lat;
        logic stale = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 1'b0; a = 16'h0100 * (i + 1); b = 16'h0001; cbin = 1'b0;
        end
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (out_valid) break;
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, result, cbo, zero, neg, ovf} !== '0) begin
            tests_failed++;
            $display("FAIL rst_inflight_outputs: got %b, want all zero", {out_valid, result, cbo, zero, neg, ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        in_valid = 1'b1; op = 1'b0; a = 16'h0102; b = 16'h0304; cbin = 1'b0;
        @(posedge clk);
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (out_valid) break;
        end
        tests_run++;
        if (lat !== STAGES) begin
            tests_failed++;
            $display("FAIL rst_new_latency: got %0d cycles, want %0d", lat, STAGES);
        end
        tests_run++;
        if ({result, cbo, zero, neg, ovf} !== {16'h0406, 4'b0000}) begin
            tests_failed++;
            $display("FAIL rst_new_result: got %h, want %h", {result, cbo, zero, neg, ovf}, {16'h0406, 4'b0000});
        end
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        tests_run++;
        if (stale !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_stale_output: stale result seen %b, want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random(2000);
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
